bus_rr_arbiter: RTL and testbench



---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/bus_rr_arbiter_rr_pick.sv | 44 ++++
 rtl/bus_rr_arbiter.sv | 95 +++++++++
 tb/tb_bus_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: default word width,
// state encoding and the source-index width helper.
package bus_arb_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // A 1- or 2-requester arbiter still needs a one-bit source index.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so rr_ptr is
// bit 0, take the lowest set bit, then rotate the index back.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = clog2_safe(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SRC_W-1:0]     rot_pos;
    logic [SRC_W:0]       idx_sum;

    assign req_dbl = {req, req} >> rr_ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];
    assign any_req = |req;

    // Scanning downward leaves the lowest set bit as the final assignment.
    always_comb begin
        rot_pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_pos = SRC_W'(i);
            end
        end
    end

    assign idx_sum   = {1'b0, rot_pos} + {1'b0, rr_ptr};
    assign grant_idx = (idx_sum >= (SRC_W+1)'(NUM_REQ))
                     ? SRC_W'(idx_sum - (SRC_W+1)'(NUM_REQ))
                     : idx_sum[SRC_W-1:0];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi] = any_req & (grant_idx == SRC_W'(gi));
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter feeding a single-entry output register tagged with the
// source index; a drain and a new load may share one edge for full throughput.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SRC_W   = clog2_safe(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready,
    output logic                        busy
);

    logic              state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [DATA_W-1:0]  req_word [NUM_REQ];
    logic [NUM_REQ-1:0] pick_grant;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;
    logic               can_load;
    logic               load;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    // rst_n gates the grant so no handshake escapes while reset is held.
    assign can_load = (state_q == ST_EMPTY) | out_ready;
    assign load     = rst_n & can_load & pick_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_src_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !load) state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            out_data_d = req_word[pick_idx];
            out_src_d  = pick_idx;
            rr_ptr_d   = (pick_idx == SRC_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        req_ready = load ? pick_grant : '0;
        busy      = (state_q == ST_FULL) & ~out_ready;
    end

    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed testbench for bus_rr_arbiter with four requesters.
module tb_bus_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    bus_rr_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hC0DE_0000 + i;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h src=%0d busy=%b expected 0/0/0/0", out_valid, out_data, out_src, busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hC0DE_0000) begin
            errors++;
            $display("FAIL reset_first_word: got valid=%b src=%0d data=%h expected 1/0/c0de0000", out_valid, out_src, out_data);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        req_data[2*32 +: 32] = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 2'd2) begin
            errors++;
            $display("FAIL single_word: got valid=%b data=%h src=%0d expected 1/deadbeef/2", out_valid, out_data, out_src);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL single_rr_ptr: got %0d expected 3", dut.rr_ptr_q); end
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_pulse_len: got %b expected 0000", req_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got valid=%b expected 0", out_valid); end
        $display("test_single: done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA000_0000 + i;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_rdy = 4'b0001 << (k % 4);
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_rdy); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== 32'hA000_0000 + 32'(k % 4)) begin
                errors++;
                $display("FAIL rr_word_%0d: got valid=%b src=%0d data=%h expected 1/%0d/%h",
                         k, out_valid, out_src, out_data, k % 4, 32'hA000_0000 + 32'(k % 4));
            end
            $display("rr transfer %0d: src=%0d data=%h", k, out_src, out_data);
        end
        req_valid = 4'b0000;
        tick();
        $display("test_round_robin: done");
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data[1*32 +: 32] = 32'h1111_1111;
        req_data[3*32 +: 32] = 32'h3333_3333;
        req_valid = 4'b0010;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall_%0d: got ready=%b busy=%b expected 0000/1", k, req_ready, busy);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 32'h1111_1111) begin
                errors++;
                $display("FAIL bp_hold_%0d: got valid=%b src=%0d data=%h expected 1/1/11111111", k, out_valid, out_src, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_grant: got ready=%b busy=%b expected 1000/0", req_ready, busy);
        end
        tick();
        req_valid = 4'b0000;
        checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 32'h3333_3333) begin
            errors++;
            $display("FAIL bp_reload: got valid=%b src=%0d data=%h expected 1/3/33333333", out_valid, out_src, out_data);
        end
        tick();
        $display("test_backpressure: done");
    endtask

    task automatic test_withdraw_idle();
        do_reset();
        req_data[0] = 1'b1;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_no_grant: got %b expected 0000", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_idle_ready: got %b expected 0000", req_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL wd_drain: got valid=%b expected 0", out_valid); end
        tick();
        checks++;
        if (dut.rr_ptr_q !== 2'd1 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL wd_rr_ptr: got ptr=%0d ready=%b expected 1/0000", dut.rr_ptr_q, req_ready);
        end
        $display("test_withdraw_idle: done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data[2*32 +: 32] = 32'h1234_5678;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mid_loaded: got valid=%b data=%h expected 1/12345678", out_valid, out_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: got valid=%b data=%h ready=%b busy=%b expected 0/0/0000/0",
                     out_valid, out_data, req_ready, busy);
        end
        req_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (dut.rr_ptr_q !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_release: got ptr=%0d valid=%b expected 0/0", dut.rr_ptr_q, out_valid);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_withdraw_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
